comparator_serial_nbit: RTL and testbench

//   Parametrised N-bit magnitude comparator, successor to the 1-bit comparator.

---
 rtl/comparator_serial_nbit_if.sv | 37 +++
 rtl/comparator_serial_nbit.sv | 114 +++++++++++
 tb/tb_comparator_serial_nbit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_serial_nbit_if.sv
// Handshake and operand bundle for the bit-serial magnitude comparator.
// The signed_mode signal exists only when CMP_SIGNED_EN is defined.
interface comparator_serial_nbit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;
`ifdef CMP_SIGNED_EN
  logic             signed_mode;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, gt, eq, lt
  );
`else
  modport master (
    output start, a, b,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, eq, lt
  );
`endif
endinterface

// File: rtl/comparator_serial_nbit.sv
// Bit-serial N-bit magnitude comparator: scans MSB first and stops at the first differing bit.
// Optional two's-complement compare is enabled by defining CMP_SIGNED_EN.
module comparator_serial_nbit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  comparator_serial_nbit_if.slave cmp
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] IdxMsb = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             bit_a, bit_b;
  logic             msb_inv;
  logic             a_wins;

`ifdef CMP_SIGNED_EN
  logic             signed_q, signed_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
`ifdef CMP_SIGNED_EN
    signed_d = signed_q;
    // A sign-bit difference means the operand with a 0 there is the larger one.
    msb_inv  = signed_q && (idx_q == IdxMsb);
`else
    msb_inv  = 1'b0;
`endif
    bit_a  = a_q[idx_q];
    bit_b  = b_q[idx_q];
    a_wins = bit_a ^ msb_inv;

    case (state_q)
      StIdle: begin
        if (cmp.start) begin
          state_d = StShift;
          a_d     = cmp.a;
          b_d     = cmp.b;
          idx_d   = IdxMsb;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
`ifdef CMP_SIGNED_EN
          signed_d = cmp.signed_mode;
`endif
        end
      end
      StShift: begin
        if (bit_a != bit_b) begin
          gt_d    = a_wins;
          lt_d    = ~a_wins;
          state_d = StDone;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
`ifdef CMP_SIGNED_EN
      signed_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
`ifdef CMP_SIGNED_EN
      signed_q <= signed_d;
`endif
    end
  end

  assign cmp.busy = (state_q != StIdle);
  assign cmp.done = (state_q == StDone);
  assign cmp.gt   = gt_q;
  assign cmp.eq   = eq_q;
  assign cmp.lt   = lt_q;

endmodule

// File: tb/tb_comparator_serial_nbit.sv
// Self-checking bench: a cycle-level behavioural model plus directed literal scenarios and
// randomized traffic including mid-operation resets.
module tb_comparator_serial_nbit;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sm = 1'b0;
  logic         chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comparator_serial_nbit_if #(.WIDTH(W)) cmp_if ();

  assign cmp_if.start = start;
  assign cmp_if.a     = a;
  assign cmp_if.b     = b;
`ifdef CMP_SIGNED_EN
  assign cmp_if.signed_mode = sm;
`endif

  comparator_serial_nbit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (cmp_if)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Edges after acceptance until resolution: WIDTH - (highest differing bit), or WIDTH if equal.
  function automatic int exp_edges(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] != y[i]) return W - i;
    end
    return W;
  endfunction

  // {gt, eq, lt}
  function automatic logic [2:0] exp_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    logic greater;
    if (x == y) return 3'b010;
    greater = s ? ($signed(x) > $signed(y)) : (x > y);
    return greater ? 3'b100 : 3'b001;
  endfunction

  logic       m_busy, m_done;
  logic [2:0] m_res, m_pend;
  int         m_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= 3'b000;
      m_pend <= 3'b000;
      m_rem  <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_rem == 1) begin
        m_res  <= m_pend;
        m_done <= 1'b1;
      end
      m_rem <= m_rem - 1;
    end else if (start) begin
      m_busy <= 1'b1;
      m_rem  <= exp_edges(a, b);
      m_pend <= exp_res(a, b, sm);
      m_res  <= 3'b000;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_vs_dut {busy,done,gt,eq,lt}",
            {27'd0, cmp_if.busy, cmp_if.done, cmp_if.gt, cmp_if.eq, cmp_if.lt},
            {27'd0, m_busy, m_done, m_res});
    end
  end

  // Waits (bounded) for done; 'first' is the edge number of the next posedge to be observed.
  task automatic wait_done(input int first, output int got);
    got = -1;
    for (int k = first; k <= W + 2; k++) begin
      @(posedge clk);
      #1;
      if (cmp_if.done) begin
        got = k;
        break;
      end
    end
  endtask

  task automatic finish_checks(input string name, input int got, input int want_edges,
                               input logic [2:0] want_res);
    check({name, " done_edge"}, got, want_edges);
    check({name, " result"}, {29'd0, cmp_if.gt, cmp_if.eq, cmp_if.lt}, {29'd0, want_res});
    @(posedge clk);
    #1;
    check({name, " held"}, {27'd0, cmp_if.busy, cmp_if.done, cmp_if.gt, cmp_if.eq, cmp_if.lt},
          {27'd0, 2'b00, want_res});
    @(negedge clk);
  endtask

  // Call while clk is low and the DUT is idle; returns at a negedge.
  task automatic run_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input int want_edges, input logic [2:0] want_res, input string name);
    int got;
    a = x;
    b = y;
    sm = s;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, got);
    finish_checks(name, got, want_edges, want_res);
  endtask

  initial begin
    int got;
    logic [W-1:0] one;
    one = 1;

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {27'd0, cmp_if.busy, cmp_if.done, cmp_if.gt, cmp_if.eq, cmp_if.lt},
          32'd0);
    chk_en = 1'b1;

    // Release and start together: the first edge after release must accept.
    @(negedge clk);
    rst_n = 1'b1;
    run_cmp(8'hA5, 8'hA5, 1'b0, 8, 3'b010, "eq_a5");
    run_cmp(8'h80, 8'h7F, 1'b0, 1, 3'b100, "msb_unsigned");
`ifdef CMP_SIGNED_EN
    run_cmp(8'h80, 8'h7F, 1'b1, 1, 3'b001, "msb_signed");
    run_cmp(8'hFE, 8'hFF, 1'b1, 8, 3'b001, "neg_lsb_signed");
`endif
    run_cmp(8'h12, 8'h13, 1'b0, 8, 3'b001, "lsb_lt");
    run_cmp(8'h40, 8'h00, 1'b0, 2, 3'b100, "bit6_gt");

    // start and operand changes while busy must be ignored.
    a = 8'h01;
    b = 8'h01;
    sm = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'hFF;
    b = 8'h00;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(4, got);
    finish_checks("ignore_start", got, 8, 3'b010);

    // Reset mid-compare aborts at once; the next compare behaves normally.
    a = 8'h0F;
    b = 8'h0E;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort outputs", {27'd0, cmp_if.busy, cmp_if.done, cmp_if.gt, cmp_if.eq, cmp_if.lt},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmp(8'h03, 8'h07, 1'b0, 6, 3'b001, "after_abort");

    // Randomized traffic; drive after the negedge so resets never race the compare process.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #2;
      rst_n = ($urandom_range(0, 199) != 0);
      start = ($urandom_range(0, 3) != 0);
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (one << $urandom_range(0, W - 1));
        default: b = W'($urandom);
      endcase
`ifdef CMP_SIGNED_EN
      sm = 1'($urandom_range(0, 1));
`endif
    end

    @(negedge clk);
    #2;
    rst_n = 1'b1;
    start = 1'b0;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
